cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares one cacheline_adaptor between the instruction cache (read-only) and the data cache (read/write). Each cache issues 256-bit line requests.
- Sits between the two cache miss ports and the adaptor's LLC-side port.
- Serves one transaction at a time, to completion. Ties are broken round-robin.
- A watchdog flags a transaction that gets no adaptor response.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles in a SERVE state without adapt_resp before timeout_err sets; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_address  in  32  I-cache line address.
- i_read  in  1  I-cache read request; held high until i_resp.
- i_line  out  256  read line returned to the I-cache.
- i_resp  out  1  one-cycle completion pulse to the I-cache.
- d_address  in  32  D-cache line address.
- d_read  in  1  D-cache read request; held until d_resp.
- d_write  in  1  D-cache write request; held until d_resp.
- d_wline  in  256  write line from the D-cache.
- d_rline  out  256  read line returned to the D-cache.
- d_resp  out  1  one-cycle completion pulse to the D-cache.
- adapt_address  out  32  to adaptor address_i.
- adapt_read  out  1  to adaptor read_i.
- adapt_write  out  1  to adaptor write_i.
- adapt_wline  out  256  to adaptor line_i.
- adapt_rline  in  256  from adaptor line_o.
- adapt_resp  in  1  from adaptor resp_o; one-cycle pulse.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, rr_last=I, cnt=0.
  - adapt_read, adapt_write, adapt_address and adapt_wline are all 0.
  - i_resp=0, d_resp=0, timeout_err=0.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE arbitration:
  - Only i_read pending: go to SERVE_I.
  - Only d_read or d_write pending: go to SERVE_D.
  - Both pending: grant the port that is not rr_last.
  - The first tie after reset therefore goes to D.
- On the IDLE->SERVE edge:
  - Register the granted port's address into adapt_address.
  - For D, register d_wline into adapt_wline.
  - Set exactly one of adapt_read or adapt_write.
  - All adaptor-side outputs are registered. The request is first seen in IDLE at cycle t; the adaptor strobe is high from t+1.
- d_read and d_write both high: treated as a write; the read is ignored.
- SERVE_x:
  - Hold adapt_read or adapt_write and hold the latched address and data.
  - Requester inputs are ignored. A request dropped mid-service is still carried to completion.
  - On adapt_resp=1, pulse x_resp combinationally in the same cycle, gated by state.
  - Then drop adapt_read and adapt_write, set rr_last=x and go to DONE.
- Read data path:
  - i_line and d_rline are wired combinationally to adapt_rline.
  - The data is valid only in the cycle the matching resp is high.
- DONE:
  - Lasts exactly one cycle with adapt_read=adapt_write=0, so the adaptor completes its reset_signals cycle.
  - No grant is made in DONE; the next state is IDLE.
  - Back-to-back requests therefore have a minimum of 2 idle cycles between adaptor strobes.
- adapt_resp outside SERVE_I/SERVE_D is ignored; no x_resp is generated.
- Watchdog:
  - cnt clears on entry to SERVE and increments each SERVE cycle without adapt_resp.
  - When cnt == TIMEOUT_CYCLES, set timeout_err (sticky until reset).
  - The transaction is not aborted; the arbiter stays in SERVE and cnt saturates.
- Reset mid-transaction: all outputs clear immediately (asynchronously), with no x_resp. The adaptor is reset separately.
- i_resp and d_resp are never high in the same cycle.

Decomposition:
- Package cacheline_arbiter_pkg holds:
  - the state enum arb_state_t with IDLE, SERVE_I, SERVE_D, DONE;
  - the port-id enum with I=0, D=1;
  - LINE_W=256 and ADDR_W=32.
- One sub-module is natural: rr_arbiter2, a 2-requester round-robin picker. It takes the two request bits and rr_last and returns a one-hot grant; it is combinational.

Test Plan:
- Single I read:
  - Stimulus: i_read=1 with i_address=0x0000_1000.
  - Required: adapt_read=1 and adapt_address=0x0000_1000 one cycle later.
  - The adaptor model returns 0xA5..A5 on adapt_resp; i_resp pulses 1 cycle with i_line=0xA5..A5; d_resp stays 0.
- D write:
  - Stimulus: d_write=1, d_address=0x0000_2040, d_wline={64'h4,64'h3,64'h2,64'h1}.
  - Required: adapt_write=1 with adapt_wline matching d_wline; adapt_read=0.
  - d_resp pulses on adapt_resp; DONE holds both adaptor strobes low for 1 cycle.
- Tie after reset:
  - Stimulus: i_read and d_read both raised in the same cycle.
  - Required: D is served first; I is granted after the DONE and IDLE cycles.
  - A second simultaneous tie goes to I, because rr_last=D at that point.
- Read and write both high:
  - Stimulus: d_read=d_write=1.
  - Required: only adapt_write is asserted.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=8, and the adaptor model never responds.
  - Required: timeout_err rises after 8 SERVE cycles and stays high.
  - A late adapt_resp still completes the transaction; timeout_err remains 1.
- Reset mid-transaction:
  - Stimulus: assert reset during SERVE_D.
  - Required: adapt_write and d_resp go to 0 without waiting for a clock edge.
  - After release, a new i_read is served normally.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// rtl/cacheline_arbiter_pkg.sv - shared types and widths for the cacheline arbiter
package cacheline_arbiter_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

endpackage

// File: rtl/cacheline_arbiter_rr_arbiter2.sv
// rtl/cacheline_arbiter_rr_arbiter2.sv - two-requester round-robin picker, one-hot grant
module rr_arbiter2
    import cacheline_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   rr_last,
    output logic [1:0] grant
);

    // bit 0 is the I port, bit 1 the D port; a tie goes to whoever was not served last
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_last == PORT_I) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - shares one cacheline adaptor between the I-cache and D-cache miss ports
module cacheline_arbiter
    import cacheline_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_line,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wline,
    output logic [LINE_W-1:0] d_rline,
    output logic              d_resp,
    output logic [ADDR_W-1:0] adapt_address,
    output logic              adapt_read,
    output logic              adapt_write,
    output logic [LINE_W-1:0] adapt_wline,
    input  logic [LINE_W-1:0] adapt_rline,
    input  logic              adapt_resp,
    output logic              timeout_err
);

    localparam bit               WD_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMO_M1 = TMO - CNT_W'(1);

    arb_state_t        state, state_nxt;
    port_id_t          rr_last, rr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [LINE_W-1:0] wline_nxt;
    logic              rd_nxt, wr_nxt, err_nxt;
    logic [1:0]        grant;

    rr_arbiter2 u_rr (
        .req     ({d_read | d_write, i_read}),
        .rr_last (rr_last),
        .grant   (grant)
    );

    assign i_line  = adapt_rline;
    assign d_rline = adapt_rline;
    assign i_resp  = (state == SERVE_I) && adapt_resp;
    assign d_resp  = (state == SERVE_D) && adapt_resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_last       <= PORT_I;
            cnt           <= '0;
            adapt_address <= '0;
            adapt_wline   <= '0;
            adapt_read    <= 1'b0;
            adapt_write   <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_nxt;
            rr_last       <= rr_nxt;
            cnt           <= cnt_nxt;
            adapt_address <= addr_nxt;
            adapt_wline   <= wline_nxt;
            adapt_read    <= rd_nxt;
            adapt_write   <= wr_nxt;
            timeout_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_last;
        cnt_nxt   = cnt;
        addr_nxt  = adapt_address;
        wline_nxt = adapt_wline;
        rd_nxt    = adapt_read;
        wr_nxt    = adapt_write;
        err_nxt   = timeout_err;
        case (state)
            IDLE: begin
                if (grant[0]) begin
                    state_nxt = SERVE_I;
                    addr_nxt  = i_address;
                    rd_nxt    = 1'b1;
                    wr_nxt    = 1'b0;
                    cnt_nxt   = '0;
                end else if (grant[1]) begin
                    // a simultaneous read and write is taken as a write
                    state_nxt = SERVE_D;
                    addr_nxt  = d_address;
                    wline_nxt = d_wline;
                    rd_nxt    = ~d_write;
                    wr_nxt    = d_write;
                    cnt_nxt   = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (adapt_resp) begin
                    rd_nxt    = 1'b0;
                    wr_nxt    = 1'b0;
                    rr_nxt    = (state == SERVE_I) ? PORT_I : PORT_D;
                    state_nxt = DONE;
                end else if (WD_EN && (cnt != TMO)) begin
                    // counter saturates at the limit; the transaction keeps waiting
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == TMO_M1)
                        err_nxt = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - directed self-checking bench for cacheline_arbiter
module tb_cacheline_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  i_address;
    logic         i_read;
    logic [255:0] i_line;
    logic         i_resp;
    logic [31:0]  d_address;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wline;
    logic [255:0] d_rline;
    logic         d_resp;
    logic [31:0]  adapt_address;
    logic         adapt_read;
    logic         adapt_write;
    logic [255:0] adapt_wline;
    logic [255:0] adapt_rline;
    logic         adapt_resp;
    logic         timeout_err;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_3C = {32{8'h3C}};
    localparam logic [255:0] WL     = {64'h4, 64'h3, 64'h2, 64'h1};

    cacheline_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_line        (i_line),
        .i_resp        (i_resp),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_wline       (d_wline),
        .d_rline       (d_rline),
        .d_resp        (d_resp),
        .adapt_address (adapt_address),
        .adapt_read    (adapt_read),
        .adapt_write   (adapt_write),
        .adapt_wline   (adapt_wline),
        .adapt_rline   (adapt_rline),
        .adapt_resp    (adapt_resp),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1;
        i_address = '0; i_read = 1'b0;
        d_address = '0; d_read = 1'b0; d_write = 1'b0; d_wline = '0;
        adapt_rline = '0; adapt_resp = 1'b0;
        step();
        chk("rst_rd",   256'(adapt_read),    256'(0));
        chk("rst_wr",   256'(adapt_write),   256'(0));
        chk("rst_addr", 256'(adapt_address), 256'(0));
        chk("rst_wl",   adapt_wline,         256'(0));
        chk("rst_iresp",256'(i_resp),        256'(0));
        chk("rst_dresp",256'(d_resp),        256'(0));
        chk("rst_err",  256'(timeout_err),   256'(0));
        reset = 1'b0;
        step();

        // single I read
        i_read = 1'b1; i_address = 32'h0000_1000;
        step();
        chk("i_rd",    256'(adapt_read),    256'(1));
        chk("i_wr",    256'(adapt_write),   256'(0));
        chk("i_addr",  256'(adapt_address), 256'(32'h0000_1000));
        chk("i_nresp", 256'(i_resp),        256'(0));
        adapt_rline = PAT_A5; adapt_resp = 1'b1;
        #1;
        chk("i_resp",  256'(i_resp), 256'(1));
        chk("i_line",  i_line,       PAT_A5);
        chk("i_dresp", 256'(d_resp), 256'(0));
        step();
        adapt_resp = 1'b0; i_read = 1'b0;
        #1;
        chk("i_done_rd",   256'(adapt_read), 256'(0));
        chk("i_done_resp", 256'(i_resp),     256'(0));
        step();

        // stray adaptor response in IDLE
        adapt_resp = 1'b1;
        #1;
        chk("stray_i", 256'(i_resp), 256'(0));
        chk("stray_d", 256'(d_resp), 256'(0));
        adapt_resp = 1'b0;

        // D write
        d_write = 1'b1; d_address = 32'h0000_2040; d_wline = WL;
        step();
        chk("dw_wr",   256'(adapt_write),   256'(1));
        chk("dw_rd",   256'(adapt_read),    256'(0));
        chk("dw_addr", 256'(adapt_address), 256'(32'h0000_2040));
        chk("dw_wl",   adapt_wline,         WL);
        adapt_resp = 1'b1;
        #1;
        chk("dw_dresp", 256'(d_resp), 256'(1));
        chk("dw_iresp", 256'(i_resp), 256'(0));
        step();
        adapt_resp = 1'b0; d_write = 1'b0;
        chk("dw_done_wr", 256'(adapt_write), 256'(0));
        chk("dw_done_rd", 256'(adapt_read),  256'(0));
        step();

        // read and write together: write wins
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_3000;
        step();
        chk("rw_wr", 256'(adapt_write), 256'(1));
        chk("rw_rd", 256'(adapt_read),  256'(0));
        adapt_resp = 1'b1;
        #1;
        chk("rw_dresp", 256'(d_resp), 256'(1));
        step();
        adapt_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
        step();

        // watchdog, request dropped mid-service
        d_read = 1'b1; d_address = 32'h0000_4000;
        step();
        chk("wd_rd", 256'(adapt_read), 256'(1));
        d_read = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("wd_err_pre", 256'(timeout_err), 256'(0));
        step();
        chk("wd_err", 256'(timeout_err), 256'(1));
        for (int k = 0; k < 4; k++) step();
        chk("wd_hold_rd",  256'(adapt_read),  256'(1));
        chk("wd_err_hold", 256'(timeout_err), 256'(1));
        adapt_rline = PAT_3C; adapt_resp = 1'b1;
        #1;
        chk("wd_dresp", 256'(d_resp),  256'(1));
        chk("wd_dline", d_rline,       PAT_3C);
        step();
        adapt_resp = 1'b0;
        chk("wd_done_rd",  256'(adapt_read),  256'(0));
        chk("wd_err_post", 256'(timeout_err), 256'(1));
        step();

        // reset in the middle of SERVE_D
        d_write = 1'b1; d_address = 32'h0000_5000; d_wline = PAT_A5;
        step();
        chk("rm_wr", 256'(adapt_write), 256'(1));
        adapt_resp = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("rm_wr0",  256'(adapt_write), 256'(0));
        chk("rm_dresp",256'(d_resp),      256'(0));
        chk("rm_err",  256'(timeout_err), 256'(0));
        adapt_resp = 1'b0; d_write = 1'b0;
        step();
        reset = 1'b0;
        step();

        // first tie after reset goes to D; held I then wins the next tie
        i_read = 1'b1; i_address = 32'h0000_6000;
        d_read = 1'b1; d_address = 32'h0000_7000;
        step();
        chk("t1_addr", 256'(adapt_address), 256'(32'h0000_7000));
        chk("t1_rd",   256'(adapt_read),    256'(1));
        adapt_resp = 1'b1;
        #1;
        chk("t1_dresp", 256'(d_resp), 256'(1));
        chk("t1_iresp", 256'(i_resp), 256'(0));
        step();
        adapt_resp = 1'b0;
        chk("t1_done_rd", 256'(adapt_read), 256'(0));
        step();
        chk("t1_idle_rd", 256'(adapt_read), 256'(0));
        step();
        chk("t2_addr", 256'(adapt_address), 256'(32'h0000_6000));
        chk("t2_rd",   256'(adapt_read),    256'(1));
        adapt_resp = 1'b1;
        #1;
        chk("t2_iresp", 256'(i_resp), 256'(1));
        chk("t2_dresp", 256'(d_resp), 256'(0));
        step();
        adapt_resp = 1'b0;
        step();
        step();
        chk("t3_addr", 256'(adapt_address), 256'(32'h0000_7000));
        adapt_resp = 1'b1;
        #1;
        chk("t3_dresp", 256'(d_resp), 256'(1));
        step();
        adapt_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
